// File: rtl/rr_arbiter.sv
// N-channel round-robin arbiter with registered one-hot grant, grant hold and rotating priority.
// Optional macro RR_ARB_HOLD_LIMIT_EN adds a hold counter that forcibly rotates long-held grants.
module rr_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (N_REQ < 2 || N_REQ > 16) begin : g_chk_nreq
        $error("rr_arbiter: N_REQ out of range");
    end
    if ((2 ** ID_W) < N_REQ) begin : g_chk_idw
        $error("rr_arbiter: ID_W too narrow for N_REQ");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_chk_hold
        $error("rr_arbiter: MAX_HOLD out of range");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;

    logic             found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  scan;
    logic             owner_req;
    logic             rotate;
    logic             take;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (v == ID_W'(N_REQ - 1)) begin
            return '0;
        end
        return v + ID_W'(1);
    endfunction

    // First set request in search order ptr, ptr+1, ... wrapping at N_REQ
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        scan   = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[scan]) begin
                found  = 1'b1;
                win_id = scan;
            end
            scan = wrap_inc(scan);
        end
    end

    assign owner_req = |(req & gnt_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        take        = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                        gnt_id_d    = '0;
                    end
                end else if (rotate) begin
                    // Owner sits at ptr-1, last in search order, so another channel wins
                    take = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take) begin
            state_d     = GRANT;
            gnt_d       = N_REQ'(1) << win_id;
            gnt_valid_d = 1'b1;
            gnt_id_d    = win_id;
            ptr_d       = wrap_inc(win_id);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RR_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       preempt_q, preempt_d;
    logic       others_req;

    assign others_req = |(req & ~gnt_q);
    // >= so a rival arriving after the counter passed the limit still forces rotation
    assign rotate = (state_q == GRANT) && (hold_cnt_q >= 8'(MAX_HOLD)) && others_req;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        if (take) begin
            hold_cnt_d = 8'd1;
            preempt_d  = rotate && owner_req;
        end else if (state_d == IDLE) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign rotate  = 1'b0;
    assign preempt = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

    a_onehot_grant: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == GRANT) ? $onehot(gnt_q) : (gnt_q == '0));
    a_id_range: assert property (@(posedge clock) disable iff (!reset_n)
        gnt_id_q <= ID_W'(N_REQ - 1));

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a queue-free integer model of the arbitration rules.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAXH     = 4;
`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN  = 1'b1;
`else
    localparam bit HOLD_EN  = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           preempt;

    int total  = 0;
    int passed = 0;

    // Model: owner index (-1 when idle), priority pointer, hold length, preempt pulse
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    rr_arbiter #(
        .N_REQ   (N),
        .ID_W    (IDW),
        .MAX_HOLD(MAXH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .preempt  (preempt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r);
        int  w;
        bool_others: begin end
        w     = -1;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
        end else if (!r[m_owner]) begin
            w = pick(r, m_ptr);
            if (w < 0) begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (HOLD_EN && m_hold >= MAXH && (r & ~(N'(1) << m_owner)) != '0) begin
            w     = pick(r, m_ptr);
            m_pre = 1'b1;
        end else begin
            m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        end
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = (w + 1) % N;
            m_hold  = 1;
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_hold  = 0;
                m_pre   = 1'b0;
            end else begin
                model_step(req);
            end
            #1;
            begin
                logic [N-1:0]   e_gnt;
                logic [IDW-1:0] e_id;
                e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
                e_id  = (m_owner < 0) ? '0 : IDW'(m_owner);
                total++;
                if (gnt === e_gnt && gnt_valid === (m_owner >= 0) && gnt_id === e_id
                    && preempt === m_pre) begin
                    passed++;
                end else begin
                    $display("FAIL model_cmp t=%0t: gnt=%b valid=%b id=%0d pre=%b, expected gnt=%b valid=%b id=%0d pre=%b",
                             $time, gnt, gnt_valid, gnt_id, preempt,
                             e_gnt, (m_owner >= 0), e_id, m_pre);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic edge_chk();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_id", int'(gnt_id), 0);
        chk("reset_preempt", int'(preempt), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Idle and one-cycle latency
        repeat (5) begin
            edge_chk();
            chk("idle_gnt", int'(gnt), 0);
        end
        @(negedge clock) req = 4'b1000;
        edge_chk();
        chk("latency_gnt", int'(gnt), 8);
        chk("latency_id", int'(gnt_id), 3);
        @(negedge clock) req = 4'b0000;
        edge_chk();
        chk("release_gnt", int'(gnt), 0);

        // Round robin with all four requesting
        @(negedge clock) req = 4'b1111;
        edge_chk();
        chk("rr_first_id", int'(gnt_id), order[0]);
        for (int r = 0; r < 4; r++) begin
            edge_chk();
            edge_chk();
            chk("rr_hold_id", int'(gnt_id), order[r]);
            @(negedge clock) req[order[r]] = 1'b0;
            edge_chk();
            chk("rr_next_id", int'(gnt_id), order[r+1]);
            chk("rr_no_bubble", int'(gnt_valid), 1);
            @(negedge clock) req = 4'b1111;
        end
        @(negedge clock) req = 4'b0000;
        edge_chk();

        // Wrap and skip from ptr=3
        @(negedge clock) req = 4'b0100;
        edge_chk();
        chk("wrap_setup_id", int'(gnt_id), 2);
        @(negedge clock) req = 4'b0000;
        edge_chk();
        @(negedge clock) req = 4'b0101;
        edge_chk();
        chk("wrap_id0", int'(gnt_id), 0);
        chk("wrap_gnt0", int'(gnt), 1);
        @(negedge clock) req = 4'b0100;
        edge_chk();
        chk("skip_id2", int'(gnt_id), 2);
        chk("skip_valid", int'(gnt_valid), 1);
        @(negedge clock) req = 4'b0000;
        edge_chk();

        // Hold limit scenario
        @(negedge clock) req = 4'b0010;
        edge_chk();
        chk("hold_first", int'(gnt), 2);
        @(negedge clock) req = 4'b1010;
        if (HOLD_EN) begin
            repeat (3) begin
                edge_chk();
                chk("hold_keep", int'(gnt), 2);
                chk("hold_nopre", int'(preempt), 0);
            end
            edge_chk();
            chk("preempt_gnt", int'(gnt), 8);
            chk("preempt_pulse", int'(preempt), 1);
            edge_chk();
            chk("preempt_after_gnt", int'(gnt), 8);
            chk("preempt_one_cycle", int'(preempt), 0);
            @(negedge clock) req = 4'b0010;
            edge_chk();
            chk("regrant_ch1", int'(gnt), 2);
        end else begin
            repeat (50) begin
                edge_chk();
                chk("nolimit_keep", int'(gnt), 2);
                chk("nolimit_nopre", int'(preempt), 0);
            end
        end
        @(negedge clock) req = 4'b0000;
        edge_chk();

        // Asynchronous reset mid-grant
        @(negedge clock) req = 4'b0100;
        edge_chk();
        chk("rst_setup_id", int'(gnt_id), 2);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_gnt", int'(gnt), 0);
        chk("rst_async_valid", int'(gnt_valid), 0);
        chk("rst_async_id", int'(gnt_id), 0);
        @(negedge clock) req = 4'b0001;
        @(negedge clock) reset_n = 1'b1;
        edge_chk();
        chk("rst_regrant", int'(gnt), 1);

        // Randomized traffic, checked by the model process
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (req[i]) req[i] = ($urandom_range(0, 7) != 0);
                else        req[i] = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clock) req = '0;
        repeat (3) edge_chk();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
N-channel round-robin bus arbiter with grant hold, the parametrised successor to the team's two-input fixed-priority arbiter. It grants one requester at a time with a one-hot registered grant. The grant is held while the owner keeps its request high. Fairness comes from a rotating priority pointer. It sits between DMA/peripheral masters and the shared SDRAM/SPI port on the DE0-Nano side.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of gnt_id; must satisfy 2**ID_W >= N_REQ
MAX_HOLD, 16, max consecutive cycles one owner may hold the grant while others wait (1..255); used only with RR_ARB_HOLD_LIMIT_EN

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous, active-low reset
req  in  N_REQ  request per channel, level, held high until served
gnt  out  N_REQ  one-hot grant, registered, all-zero when idle
gnt_valid  out  1  OR of gnt, registered
gnt_id  out  ID_W  binary index of current owner; 0 when idle
preempt  out  1  one-cycle pulse on the edge where a grant is forcibly rotated

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). Assertion immediately clears gnt=0, gnt_valid=0, gnt_id=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Deassertion is synchronised by the integrator.
- ptr (ID_W bits) is the highest-priority index. The search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1, modulo N_REQ, not 2**ID_W.
- IDLE: if req!=0 at an edge, the first set bit in search order wins. gnt, gnt_id and gnt_valid update on that edge, so latency is 1 cycle from req to gnt. State becomes GRANT, hold_cnt=1, ptr=winner+1 (wraps N_REQ-1 -> 0).
- GRANT, owner keeps req high: grant is held and hold_cnt increments, saturating at 255.
- GRANT, owner drops req: on that edge, if another req is set, the next winner in search order from ptr is granted immediately (no bubble) and hold_cnt=1. Otherwise gnt=0 and state=IDLE.
- Exactly one gnt bit is high in GRANT, and zero bits are high in IDLE.
- Simultaneous requests: rotation alone decides. Index value never decides.
- Request rise and fall in the same cycle as a release are sampled only at the edge.
- Non-owner request changes never disturb an active grant unless a preemption fires.
- Channel indices >= N_REQ do not exist. gnt_id never exceeds N_REQ-1.
- Single requester: the same channel may be re-granted back-to-back after its own release only if it is the sole requester.
- reset_n asserted mid-grant drops the grant at once. No state survives.

Optional Feature:
RR_ARB_HOLD_LIMIT_EN
- Defined: in GRANT, when hold_cnt==MAX_HOLD and any other req is set, the grant rotates on the next edge even though the owner's req is still high. The rotation goes to the next winner from ptr, with preempt=1 for one cycle and hold_cnt=1. The preempted owner keeps its req and competes normally.
- Defined, no other requester: the owner keeps the grant and hold_cnt saturates.
- Not defined: no hold counter is built, preempt is tied to 0, and the owner holds the grant indefinitely.

Test Plan:
- Reset: drive reset_n=0 mid-grant of ch2 -> gnt=0000, gnt_valid=0, gnt_id=0 immediately. After release with req=0001, gnt=0001 one edge later.
- Round-robin: N_REQ=4, req=1111 held, each owner drops req for 1 cycle after 3 cycles of grant -> grant order ch0,ch1,ch2,ch3,ch0 with no idle cycle between owners.
- Wrap and skip: ptr=3 (after ch2 served), req=0101 -> ch0 granted, then ch2. gnt_id=0 then 2.
- Idle/latency: req=0000 for 5 cycles, then req=1000 at edge k -> gnt=1000 at edge k+1. Drop req -> gnt=0000 on the next edge.
- Hold limit (macro defined, MAX_HOLD=4): ch1 holds req, ch3 requests at cycle 2 -> after 4 grant cycles gnt moves 0010->1000 with preempt=1 for one cycle. ch1 is regranted when ch3 releases.
- Hold limit (macro undefined): same stimulus -> ch1 keeps gnt for 50 cycles and preempt stays 0.
